// File: rtl/rect_obstacle_ctrl_pkg.sv
// Shared encodings for the rectangle obstacle: modes, button codes, FSM states.
package rect_obstacle_pkg;

  localparam int COLOR_W = 4;

  typedef enum logic [1:0] {
    MODE_MANUAL   = 2'd0,
    MODE_PATROL_H = 2'd1,
    MODE_PATROL_V = 2'd2,
    MODE_HOLD     = 2'd3
  } mode_t;

  // One-hot button codes {U,D,R,L}
  localparam logic [3:0] BTN_U = 4'd8;
  localparam logic [3:0] BTN_D = 4'd4;
  localparam logic [3:0] BTN_R = 4'd2;
  localparam logic [3:0] BTN_L = 4'd1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rect_obstacle_ctrl_contact.sv
// rect_contact_detect: combinational player-vs-rectangle edge contact and overlap tests.
// Build macro STRADDLE_BLOCK_EN also blocks a same-colour player straddling a vertical edge at top/bottom.
module rect_contact_detect
  import rect_obstacle_pkg::*;
#(
  parameter int POS_W    = 12,
  parameter int PLAYER_W = 12,
  parameter int PLAYER_H = 12
) (
  input  logic [POS_W-1:0]   rectH,
  input  logic [POS_W-1:0]   rectV,
  input  logic [POS_W-1:0]   objW,
  input  logic [POS_W-1:0]   objH,
  input  logic [POS_W-1:0]   playerH,
  input  logic [POS_W-1:0]   playerV,
  input  logic [COLOR_W-1:0] rectColor,
  input  logic [COLOR_W-1:0] playerColor,
  output logic               blockUp,
  output logic               blockDown,
  output logic               blockLeft,
  output logic               blockRight,
  output logic               overlap
);

  localparam int AW = POS_W + 2;
  localparam logic [AW-1:0] PW_A = AW'(PLAYER_W);
  localparam logic [AW-1:0] PH_A = AW'(PLAYER_H);

  logic [AW-1:0] rL, rR, rT, rB, pL, pR, pT, pB;
  logic hov, vov, colorDiff, straddle;

  // Widened edges so right/bottom sums never wrap
  assign rL = AW'(rectH);
  assign rR = AW'(rectH) + AW'(objW);
  assign rT = AW'(rectV);
  assign rB = AW'(rectV) + AW'(objH);
  assign pL = AW'(playerH);
  assign pR = AW'(playerH) + PW_A;
  assign pT = AW'(playerV);
  assign pB = AW'(playerV) + PH_A;

  assign hov       = (pL < rR) && (pR > rL);
  assign vov       = (pT < rB) && (pB > rT);
  assign colorDiff = (rectColor != playerColor);

`ifdef STRADDLE_BLOCK_EN
  assign straddle = ((pL < rL) && (rL < pR)) || ((pL < rR) && (rR < pR));
`else
  assign straddle = 1'b0;
`endif

  assign blockDown  = hov && (pB == rT) && (colorDiff || straddle);
  assign blockUp    = hov && (pT == rB) && (colorDiff || straddle);
  assign blockLeft  = vov && (pL == rR) && colorDiff;
  assign blockRight = vov && (pR == rL) && colorDiff;
  assign overlap    = hov && vov;

endmodule

// File: rtl/rect_obstacle_ctrl.sv
// rect_obstacle_ctrl: movable playfield obstacle (manual / patrol bounce) with registered contact blocks.
// Optional build macro STRADDLE_BLOCK_EN is handled inside rect_contact_detect.
module rect_obstacle_ctrl
  import rect_obstacle_pkg::*;
#(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int PLAYER_W   = 12,
  parameter int PLAYER_H   = 12,
  parameter int POS_W      = 12,
  parameter int STEP       = 1,
  parameter int PATROL_DIV = 4
) (
  input  logic               btnClk,
  input  logic               rst,
  input  logic               visible,
  input  logic [1:0]         mode,
  input  logic               load,
  input  logic [3:0]         btns,
  input  logic [POS_W-1:0]   h_start,
  input  logic [POS_W-1:0]   v_start,
  input  logic [POS_W-1:0]   obj_w,
  input  logic [POS_W-1:0]   obj_h,
  input  logic [COLOR_W-1:0] rect_color,
  input  logic [COLOR_W-1:0] player_color,
  input  logic [POS_W-1:0]   player_h,
  input  logic [POS_W-1:0]   player_v,
  output logic [POS_W-1:0]   rect_h,
  output logic [POS_W-1:0]   rect_v,
  output logic [POS_W-1:0]   obj_w_o,
  output logic [POS_W-1:0]   obj_h_o,
  output logic [COLOR_W-1:0] rect_color_o,
  output logic               visible_o,
  output logic               block_up,
  output logic               block_down,
  output logic               block_left,
  output logic               block_right,
  output logic               overlap
);

  localparam int AW    = POS_W + 2;
  localparam int DIV_W = (PATROL_DIV > 1) ? $clog2(PATROL_DIV) : 1;
  localparam logic [AW-1:0]    STEP_A   = AW'(STEP);
  localparam logic [AW-1:0]    SW_A     = AW'(SCREEN_W);
  localparam logic [AW-1:0]    SH_A     = AW'(SCREEN_H);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PATROL_DIV - 1);

  state_t           state;
  mode_t            modeSel;
  logic [1:0]       modePrev;
  logic             dirPos;
  logic [DIV_W-1:0] divCnt;

  logic [AW-1:0]    hPos, vPos, oW, oH, limH, limV, axisPos, axisLim;
  logic [POS_W-1:0] manH, manV, patrolPos;
  logic             patrolFlip, isPatrol, patrolV, patrolStep, modeChanged, reload;
  logic             cUp, cDown, cLeft, cRight, cOverlap;

  assign modeSel     = mode_t'(mode);
  assign modeChanged = (mode != modePrev);
  assign reload      = (state == ST_INIT) || load;

  assign hPos = AW'(rect_h);
  assign vPos = AW'(rect_v);
  assign oW   = AW'(obj_w);
  assign oH   = AW'(obj_h);
  // Highest legal top-left on each axis; an oversized object pins to 0
  assign limH = (SW_A >= oW) ? SW_A - oW : '0;
  assign limV = (SH_A >= oH) ? SH_A - oH : '0;

  always_comb begin
    manH = rect_h;
    manV = rect_v;
    case (btns)
      BTN_U:   manV = (vPos >= STEP_A) ? POS_W'(vPos - STEP_A) : POS_W'(SH_A - oH);
      BTN_D:   manV = (vPos + oH + STEP_A <= SH_A) ? POS_W'(vPos + STEP_A) : '0;
      BTN_R:   manH = (hPos + oW + STEP_A <= SW_A) ? POS_W'(hPos + STEP_A) : '0;
      BTN_L:   manH = (hPos >= STEP_A) ? POS_W'(hPos - STEP_A) : POS_W'(SW_A - oW);
      default: ;
    endcase
  end

  assign patrolV    = (modeSel == MODE_PATROL_V);
  assign isPatrol   = (modeSel == MODE_PATROL_H) || patrolV;
  assign axisPos    = patrolV ? vPos : hPos;
  assign axisLim    = patrolV ? limV : limH;
  // A mode change restarts the divider, so no step is taken on that edge
  assign patrolStep = isPatrol && !modeChanged && (divCnt == DIV_LAST);

  always_comb begin
    patrolPos  = POS_W'(axisPos);
    patrolFlip = 1'b0;
    if (dirPos) begin
      if (axisPos + STEP_A >= axisLim) begin
        patrolPos  = POS_W'(axisLim);
        patrolFlip = 1'b1;
      end else begin
        patrolPos = POS_W'(axisPos + STEP_A);
      end
    end else if (axisPos <= STEP_A) begin
      patrolPos  = '0;
      patrolFlip = 1'b1;
    end else begin
      patrolPos = POS_W'(axisPos - STEP_A);
    end
  end

  rect_contact_detect #(
    .POS_W    (POS_W),
    .PLAYER_W (PLAYER_W),
    .PLAYER_H (PLAYER_H)
  ) u_contact (
    .rectH       (rect_h),
    .rectV       (rect_v),
    .objW        (obj_w),
    .objH        (obj_h),
    .playerH     (player_h),
    .playerV     (player_v),
    .rectColor   (rect_color),
    .playerColor (player_color),
    .blockUp     (cUp),
    .blockDown   (cDown),
    .blockLeft   (cLeft),
    .blockRight  (cRight),
    .overlap     (cOverlap)
  );

  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      state       <= ST_INIT;
      rect_h      <= '0;
      rect_v      <= '0;
      dirPos      <= 1'b1;
      divCnt      <= '0;
      modePrev    <= MODE_MANUAL;
      block_up    <= 1'b0;
      block_down  <= 1'b0;
      block_left  <= 1'b0;
      block_right <= 1'b0;
      overlap     <= 1'b0;
    end else begin
      modePrev    <= mode;
      block_up    <= visible && cUp;
      block_down  <= visible && cDown;
      block_left  <= visible && cLeft;
      block_right <= visible && cRight;
      overlap     <= visible && cOverlap;

      if (reload) begin
        rect_h <= h_start;
        rect_v <= v_start;
        state  <= ST_RUN;
      end else begin
        case (modeSel)
          MODE_MANUAL: begin
            rect_h <= manH;
            rect_v <= manV;
          end
          MODE_PATROL_H: if (patrolStep) rect_h <= patrolPos;
          MODE_PATROL_V: if (patrolStep) rect_v <= patrolPos;
          default: ;
        endcase
      end

      if (reload || modeChanged || !isPatrol || (divCnt == DIV_LAST))
        divCnt <= '0;
      else
        divCnt <= divCnt + DIV_W'(1);

      if (modeChanged)
        dirPos <= 1'b1;
      else if (!reload && patrolStep && patrolFlip)
        dirPos <= ~dirPos;
    end
  end

  assign obj_w_o      = obj_w;
  assign obj_h_o      = obj_h;
  assign rect_color_o = rect_color;
  assign visible_o    = visible;

endmodule

// File: tb/tb_rect_obstacle_ctrl.sv
// Bench for rect_obstacle_ctrl: vector table, hand sequences, and random stimulus vs a reference model.
module tb_rect_obstacle_ctrl;

  localparam int SW = 640, SH = 480, PW = 12, PH = 12, STEP = 1, DIV = 4;

  logic        btnClk = 1'b0;
  logic        rst;
  logic        visible;
  logic [1:0]  mode;
  logic        load;
  logic [3:0]  btns;
  logic [11:0] h_start, v_start, obj_w, obj_h, player_h, player_v;
  logic [3:0]  rect_color, player_color;
  logic [11:0] rect_h, rect_v, obj_w_o, obj_h_o;
  logic [3:0]  rect_color_o;
  logic        visible_o, block_up, block_down, block_left, block_right, overlap;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int   mH, mV, mDiv, mPrevMode;
  bit   mDirPos, mInit;
  logic [4:0] mBlk;

  always #5 btnClk = ~btnClk;

  rect_obstacle_ctrl dut (
    .btnClk(btnClk), .rst(rst), .visible(visible), .mode(mode), .load(load), .btns(btns),
    .h_start(h_start), .v_start(v_start), .obj_w(obj_w), .obj_h(obj_h),
    .rect_color(rect_color), .player_color(player_color),
    .player_h(player_h), .player_v(player_v),
    .rect_h(rect_h), .rect_v(rect_v), .obj_w_o(obj_w_o), .obj_h_o(obj_h_o),
    .rect_color_o(rect_color_o), .visible_o(visible_o),
    .block_up(block_up), .block_down(block_down), .block_left(block_left),
    .block_right(block_right), .overlap(overlap)
  );

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic modelReset();
    mH = 0; mV = 0; mDiv = 0; mPrevMode = 0; mDirPos = 1; mInit = 1; mBlk = '0;
  endtask

  // Next state from the rules, using the inputs that will be present at the coming edge
  task automatic modelEdge();
    int ph, pv, ow, oh, md, p, lim;
    bit hov, vov, diff, sd, changed, wasInit, stepNow, patrol;
    ph = int'(player_h); pv = int'(player_v);
    ow = int'(obj_w);    oh = int'(obj_h);   md = int'(mode);
    hov  = (ph < mH + ow) && (ph + PW > mH);
    vov  = (pv < mV + oh) && (pv + PH > mV);
    diff = (rect_color != player_color);
    sd   = 1'b0;
`ifdef STRADDLE_BLOCK_EN
    sd = (ph < mH && mH < ph + PW) || (ph < mH + ow && mH + ow < ph + PW);
`endif
    if (visible)
      mBlk = {hov && pv == mV + oh && (diff || sd), hov && pv + PH == mV && (diff || sd),
              vov && ph == mH + ow && diff, vov && ph + PW == mH && diff, hov && vov};
    else
      mBlk = '0;

    changed = (md != mPrevMode);
    mPrevMode = md;
    wasInit = mInit;
    patrol = (md == 1 || md == 2);
    stepNow = patrol && !changed && (mDiv == DIV - 1);
    if (mInit || load) begin
      mH = int'(h_start); mV = int'(v_start); mInit = 0;
    end else if (md == 0) begin
      case (int'(btns))
        8: mV = (mV >= STEP) ? mV - STEP : SH - oh;
        4: mV = (mV + oh + STEP <= SH) ? mV + STEP : 0;
        2: mH = (mH + ow + STEP <= SW) ? mH + STEP : 0;
        1: mH = (mH >= STEP) ? mH - STEP : SW - ow;
        default: ;
      endcase
    end else if (stepNow) begin
      p   = (md == 1) ? mH : mV;
      lim = (md == 1) ? ((SW > ow) ? SW - ow : 0) : ((SH > oh) ? SH - oh : 0);
      if (mDirPos) p = p + STEP; else p = p - STEP;
      if (p >= lim && mDirPos) begin p = lim; mDirPos = 0; end
      else if (p <= 0 && !mDirPos) begin p = 0; mDirPos = 1; end
      if (md == 1) mH = p; else mV = p;
    end
    if (wasInit || load || changed || !patrol) mDiv = 0;
    else mDiv = (mDiv + 1) % DIV;
    if (changed) mDirPos = 1;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      modelEdge();
      @(posedge btnClk);
      #1;
      chk("rect_h", int'(rect_h), mH);
      chk("rect_v", int'(rect_v), mV);
      chk("contact{u,d,l,r,ov}", int'({block_up, block_down, block_left, block_right, overlap}), int'(mBlk));
    end
  endtask

  typedef struct {
    int md, ld, bt, hs, vs, ow, oh, rc, pc, ph, pv, vis, n, eh, ev, eb;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int sdExp, ph, pv;
`ifdef STRADDLE_BLOCK_EN
    sdExp = 8;
`else
    sdExp = 0;
`endif
    //              md ld bt  hs   vs  ow  oh rc pc  ph   pv vis n   eh   ev  eb
    tbl.push_back('{3, 0, 0, 100,  50, 40, 20, 3, 3, 600, 400, 1, 1, 100,  50,  0});
    tbl.push_back('{0, 1, 0, 100,   0, 40, 20, 3, 3, 600, 400, 1, 1, 100,   0,  0});
    tbl.push_back('{0, 0, 8, 100,   0, 40, 20, 3, 3, 600, 400, 1, 1, 100, 460, -1});
    tbl.push_back('{0, 0, 4, 100,   0, 40, 20, 3, 3, 600, 400, 1, 1, 100,   0, -1});
    tbl.push_back('{0, 0,12, 100,   0, 40, 20, 3, 3, 600, 400, 1, 1, 100,   0, -1});
    tbl.push_back('{0, 0, 1, 100,   0, 40, 20, 3, 3, 600, 400, 1, 1,  99,   0, -1});
    tbl.push_back('{0, 1, 0,   0,   0, 40, 20, 3, 3, 600, 400, 1, 1,   0,   0, -1});
    tbl.push_back('{0, 0, 1,   0,   0, 40, 20, 3, 3, 600, 400, 1, 1, 600,   0, -1});
    tbl.push_back('{0, 0, 2,   0,   0, 40, 20, 3, 3, 600, 400, 1, 1,   0,   0, -1});
    tbl.push_back('{1, 1, 0, 598,  50, 40, 20, 3, 3, 300, 400, 1, 1, 598,  50, -1});
    tbl.push_back('{1, 0, 8, 598,  50, 40, 20, 3, 3, 300, 400, 1, 3, 598,  50, -1});
    tbl.push_back('{1, 0, 8, 598,  50, 40, 20, 3, 3, 300, 400, 1, 1, 599,  50, -1});
    tbl.push_back('{1, 0, 8, 598,  50, 40, 20, 3, 3, 300, 400, 1, 4, 600,  50, -1});
    tbl.push_back('{1, 0, 8, 598,  50, 40, 20, 3, 3, 300, 400, 1, 4, 599,  50, -1});
    tbl.push_back('{3, 1, 0, 100,  50, 40, 20, 3, 5, 110,  38, 1, 1, 100,  50, -1});
    tbl.push_back('{3, 0, 0, 100,  50, 40, 20, 3, 5, 110,  38, 1, 1, 100,  50,  8});
    tbl.push_back('{3, 0, 0, 100,  50, 40, 20, 3, 3, 110,  38, 1, 1, 100,  50,  0});
    tbl.push_back('{3, 0, 0, 100,  50, 40, 20, 3, 5, 140,  55, 1, 1, 100,  50,  4});
    tbl.push_back('{3, 0, 0, 100,  50, 40, 20, 3, 5, 140,  55, 0, 1, 100,  50,  0});
    tbl.push_back('{3, 0, 0, 100,  50, 40, 20, 3, 3,  95,  38, 1, 1, 100,  50, sdExp});
    tbl.push_back('{3, 0, 0, 100,  50, 40, 20, 3, 5, 110,  55, 1, 1, 100,  50,  1});
    tbl.push_back('{3, 0, 0, 100,  50, 40, 20, 3, 5, 110,  70, 1, 1, 100,  50, 16});
    tbl.push_back('{3, 0, 0, 100,  50, 40, 20, 3, 5,  88,  55, 1, 1, 100,  50,  2});

    // Power-on reset
    rst = 1'b1; visible = 1'b1; mode = 2'd3; load = 1'b0; btns = 4'd0;
    h_start = 12'd100; v_start = 12'd50; obj_w = 12'd40; obj_h = 12'd20;
    rect_color = 4'd3; player_color = 4'd3; player_h = 12'd600; player_v = 12'd400;
    modelReset();
    repeat (2) @(negedge btnClk);
    chk("reset_pos", int'({rect_h, rect_v}), 0);
    chk("reset_blk", int'({block_up, block_down, block_left, block_right, overlap}), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      mode = 2'(tbl[i].md); load = 1'(tbl[i].ld); btns = 4'(tbl[i].bt);
      h_start = 12'(tbl[i].hs); v_start = 12'(tbl[i].vs);
      obj_w = 12'(tbl[i].ow); obj_h = 12'(tbl[i].oh);
      rect_color = 4'(tbl[i].rc); player_color = 4'(tbl[i].pc);
      player_h = 12'(tbl[i].ph); player_v = 12'(tbl[i].pv); visible = 1'(tbl[i].vis);
      step(tbl[i].n);
      chk($sformatf("tbl%0d_h", i), int'(rect_h), tbl[i].eh);
      chk($sformatf("tbl%0d_v", i), int'(rect_v), tbl[i].ev);
      if (tbl[i].eb >= 0)
        chk($sformatf("tbl%0d_blk", i),
            int'({block_up, block_down, block_left, block_right, overlap}), tbl[i].eb);
    end
    chk("passthru", int'({obj_w_o, obj_h_o, rect_color_o, visible_o}),
        int'({obj_w, obj_h, rect_color, visible}));

    // Mode change mid-count restarts the divider on the new axis
    player_h = 12'd600; player_v = 12'd450; btns = 4'd0;
    mode = 2'd1; load = 1'b1; h_start = 12'd300; v_start = 12'd200;
    step(1);
    load = 1'b0;
    step(2);
    mode = 2'd2;
    step(4);
    chk("modechg_v_hold", int'(rect_v), 200);
    step(1);
    chk("modechg_v_step", int'(rect_v), 201);
    chk("modechg_h_kept", int'(rect_h), 300);

    // Asynchronous reset mid-move, then INIT reload
    @(negedge btnClk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pos", int'({rect_h, rect_v}), 0);
    chk("async_rst_blk", int'({block_up, block_down, block_left, block_right, overlap}), 0);
    @(negedge btnClk);
    rst = 1'b0;
    modelReset();
    step(1);
    chk("post_rst_h", int'(rect_h), 300);
    chk("post_rst_v", int'(rect_v), 200);

    // Randomised run against the reference model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      load = ($urandom_range(0, 31) == 0);
      case ($urandom_range(0, 5))
        0: btns = 4'd8;
        1: btns = 4'd4;
        2: btns = 4'd2;
        3: btns = 4'd1;
        4: btns = 4'd0;
        default: btns = 4'($urandom);
      endcase
      if ($urandom_range(0, 63) == 0) begin
        obj_w = 12'($urandom_range(1, 200)); obj_h = 12'($urandom_range(1, 200));
        h_start = 12'($urandom_range(0, 639)); v_start = 12'($urandom_range(0, 479));
      end
      case ($urandom_range(0, 3))
        0: ph = mH - PW;
        1: ph = mH + int'(obj_w);
        2: ph = mH + $urandom_range(0, 40) - 20;
        default: ph = $urandom_range(0, 700);
      endcase
      case ($urandom_range(0, 3))
        0: pv = mV - PH;
        1: pv = mV + int'(obj_h);
        2: pv = mV + $urandom_range(0, 40) - 20;
        default: pv = $urandom_range(0, 500);
      endcase
      player_h = 12'((ph < 0) ? 0 : ph);
      player_v = 12'((pv < 0) ? 0 : pv);
      rect_color = 4'($urandom_range(0, 3));
      player_color = 4'($urandom_range(0, 3));
      visible = ($urandom_range(0, 9) != 0);
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
